// File: rtl/wb_writer_if.sv
// wb_writer_if: groups the handshake and bus signals of the writeback driver.
//   alu_*      : single-cycle ALU result (always accepted)
//   lsu_*      : LSU result with valid/ready handshake
//   wb_*       : register-file write port (rd / rd_data_in / we)
// Modports:
//   master : producer / register-file side (drives ALU and LSU inputs)
//   slave  : wb_writer side
interface wb_writer_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready, wb_we, wb_rd, wb_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output lsu_ready, wb_we, wb_rd, wb_data
  );
endinterface

// File: rtl/wb_writer.sv
// wb_writer: writeback driver for the register file's single write port.
// Merges the ALU path (highest priority, never stalled) with LSU results that
// are buffered in a DEPTH-entry FIFO. ALU writes squash older queued LSU
// entries targeting the same register (WAW), so the younger ALU value wins.
// Ports:
//   clk, reset    : clock (rising edge), synchronous active-high reset
//   bus (slave)   : alu_*, lsu_* handshake, registered wb_we/wb_rd/wb_data
//   pending_mask  : bit i set while a live queued entry targets register i
//   fifo_count    : FIFO occupancy, squashed entries included
// Optional (macro WB_WRITER_STATS_EN): stat_alu_wr, stat_lsu_wr, stat_squash
//   event counters, wrapping at 2^32.
module wb_writer #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  wb_writer_if.slave    bus,
  output logic [31:0]   pending_mask,
  output logic [AW:0]   fifo_count
`ifdef WB_WRITER_STATS_EN
  ,
  output logic [31:0]   stat_alu_wr,
  output logic [31:0]   stat_lsu_wr,
  output logic [31:0]   stat_squash
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic              live_r [DEPTH];
  logic [4:0]        rd_r   [DEPTH];
  logic [31:0]       data_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              ready_r;
  logic              wb_we_r;
  logic [4:0]        wb_rd_r;
  logic [31:0]       wb_data_r;

  logic              alu_wr_s;
  logic              push_s;
  logic              pop_s;
  logic              push_live_s;
  logic              head_live_s;
  logic [AW:0]       count_next_s;
  logic [DEPTH-1:0]  occ_s;
  logic [DEPTH-1:0]  kill_s;
  logic [31:0]       mask_s;
  logic [AW-1:0]     off_s;

  // Handshake, pop decision and live-bit of an incoming entry.
  always_comb begin
    alu_wr_s     = bus.alu_valid && (bus.alu_rd != 5'd0);
    push_s       = bus.lsu_valid && ready_r;
    // Any ALU slot (even rd==0) owns the write port, so the FIFO waits.
    pop_s        = !bus.alu_valid && (count_r != {(AW+1){1'b0}});
    push_live_s  = (bus.lsu_rd != 5'd0) && !(alu_wr_s && (bus.lsu_rd == bus.alu_rd));
    head_live_s  = live_r[rd_ptr_r];
    count_next_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
  end

  // Per-entry occupancy, WAW squash hits and the pending-write mask.
  always_comb begin
    occ_s  = {DEPTH{1'b0}};
    kill_s = {DEPTH{1'b0}};
    mask_s = 32'd0;
    off_s  = {AW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      // Distance from the head decides whether slot i holds a queued entry.
      off_s     = AW'(i) - rd_ptr_r;
      occ_s[i]  = ({1'b0, off_s} < count_r);
      kill_s[i] = occ_s[i] && live_r[i] && alu_wr_s && (rd_r[i] == bus.alu_rd);
      mask_s    = mask_s | ((occ_s[i] && live_r[i]) ? (32'd1 << rd_r[i]) : 32'd0);
    end
    mask_s[0] = 1'b0;
  end

  // FIFO storage, pointers, ready flag and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        live_r[i] <= 1'b0;
        rd_r[i]   <= 5'd0;
        data_r[i] <= 32'd0;
      end
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {(AW+1){1'b0}};
      ready_r   <= 1'b0;
      wb_we_r   <= 1'b0;
      wb_rd_r   <= 5'd0;
      wb_data_r <= 32'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_s[i]) begin
          live_r[i] <= 1'b0;
        end
      end
      if (push_s) begin
        live_r[wr_ptr_r] <= push_live_s;
        rd_r[wr_ptr_r]   <= bus.lsu_rd;
        data_r[wr_ptr_r] <= bus.lsu_data;
        wr_ptr_r         <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      // Ready is computed from next-state occupancy: no pass-through when full.
      ready_r <= (count_next_s != FULL_CNT);
      if (bus.alu_valid) begin
        wb_we_r <= alu_wr_s;
        if (alu_wr_s) begin
          wb_rd_r   <= bus.alu_rd;
          wb_data_r <= bus.alu_data;
        end
      end else if (pop_s) begin
        // Squashed heads still take one drain cycle, with no write.
        wb_we_r <= head_live_s;
        if (head_live_s) begin
          wb_rd_r   <= rd_r[rd_ptr_r];
          wb_data_r <= data_r[rd_ptr_r];
        end
      end else begin
        wb_we_r <= 1'b0;
      end
    end
  end

  assign bus.lsu_ready = ready_r;
  assign bus.wb_we     = wb_we_r;
  assign bus.wb_rd     = wb_rd_r;
  assign bus.wb_data   = wb_data_r;
  assign pending_mask  = mask_s;
  assign fifo_count    = count_r;

`ifdef WB_WRITER_STATS_EN
  logic [31:0] stat_alu_r;
  logic [31:0] stat_lsu_r;
  logic [31:0] stat_sq_r;

  // Event counters; several squashes in one cycle count as one event.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_alu_r <= 32'd0;
      stat_lsu_r <= 32'd0;
      stat_sq_r  <= 32'd0;
    end else begin
      stat_alu_r <= stat_alu_r + {31'd0, alu_wr_s};
      stat_lsu_r <= stat_lsu_r + {31'd0, (pop_s && head_live_s)};
      stat_sq_r  <= stat_sq_r + {31'd0, ((|kill_s) || (push_s && !push_live_s))};
    end
  end

  assign stat_alu_wr = stat_alu_r;
  assign stat_lsu_wr = stat_lsu_r;
  assign stat_squash = stat_sq_r;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: table-driven directed bench for wb_writer (DEPTH=4), plus
// hand-written sequences for squash, same-cycle collision and mid-drain reset.
module tb_wb_writer;
  logic        clk;
  logic        reset;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;
`ifdef WB_WRITER_STATS_EN
  logic [31:0] stat_alu_wr;
  logic [31:0] stat_lsu_wr;
  logic [31:0] stat_squash;
  logic [31:0] sq_before;
`endif
  int total;
  int bad;

  wb_writer_if bus ();

  wb_writer #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count)
`ifdef WB_WRITER_STATS_EN
    ,
    .stat_alu_wr  (stat_alu_wr),
    .stat_lsu_wr  (stat_lsu_wr),
    .stat_squash  (stat_squash)
`endif
  );

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_d;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_ready;
    logic [2:0]  e_cnt;
    logic [31:0] e_mask;
  } vec_t;

  vec_t vecs [18];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_data  = ad;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lr;
    bus.lsu_data  = ld;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] rd,
                         input logic [31:0] data, input logic rdy,
                         input logic [2:0] cnt, input logic [31:0] mask);
    chk({tag, ".we"},    {31'd0, bus.wb_we},     {31'd0, we});
    chk({tag, ".rd"},    {27'd0, bus.wb_rd},     {27'd0, rd});
    chk({tag, ".data"},  bus.wb_data,            data);
    chk({tag, ".ready"}, {31'd0, bus.lsu_ready}, {31'd0, rdy});
    chk({tag, ".count"}, {29'd0, fifo_count},    {29'd0, cnt});
    chk({tag, ".mask"},  pending_mask,           mask);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //          alu_v  rd     data           lsu_v  rd     data          we    rd     data           rdy   cnt   mask
    vecs[0]  = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h0000_1234, 1'b1, 3'd0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  32'h0000_1234, 1'b1, 3'd0, 32'h0};
    vecs[2]  = '{1'b1, 5'd10, 32'h100,       1'b1, 5'd1,  32'hD1,       1'b1, 5'd10, 32'h100,       1'b1, 3'd1, 32'h2};
    vecs[3]  = '{1'b1, 5'd11, 32'h101,       1'b1, 5'd2,  32'hD2,       1'b1, 5'd11, 32'h101,       1'b1, 3'd2, 32'h6};
    vecs[4]  = '{1'b1, 5'd12, 32'h102,       1'b1, 5'd3,  32'hD3,       1'b1, 5'd12, 32'h102,       1'b1, 3'd3, 32'hE};
    vecs[5]  = '{1'b1, 5'd13, 32'h103,       1'b1, 5'd4,  32'hD4,       1'b1, 5'd13, 32'h103,       1'b0, 3'd4, 32'h1E};
    vecs[6]  = '{1'b1, 5'd14, 32'h104,       1'b1, 5'd20, 32'hEE,       1'b1, 5'd14, 32'h104,       1'b0, 3'd4, 32'h1E};
    vecs[7]  = '{1'b1, 5'd15, 32'h105,       1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 32'h105,       1'b0, 3'd4, 32'h1E};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  32'hD1,        1'b1, 3'd3, 32'h1C};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  32'hD2,        1'b1, 3'd2, 32'h18};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'hD3,        1'b1, 3'd1, 32'h10};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'hD4,        1'b1, 3'd0, 32'h0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd4,  32'hD4,        1'b1, 3'd0, 32'h0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd6,  32'h66,       1'b0, 5'd4,  32'hD4,        1'b1, 3'd1, 32'h40};
    vecs[14] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd8,  32'h88,       1'b1, 5'd6,  32'h66,        1'b1, 3'd1, 32'h100};
    vecs[15] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'h88,        1'b1, 3'd0, 32'h0};
    vecs[16] = '{1'b1, 5'd0,  32'hFFFF,      1'b1, 5'd0,  32'h77,       1'b0, 5'd8,  32'h88,        1'b1, 3'd1, 32'h0};
    vecs[17] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd8,  32'h88,        1'b1, 3'd0, 32'h0};

    // Reset for two cycles, then release.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    reset = 1'b0;
    tick();
    chk_out("post_reset", 1'b0, 5'd0, 32'h0, 1'b1, 3'd0, 32'h0);

    // Table: ALU single write, ALU stall with full FIFO, drain order, wrap, rd==0.
    for (int v = 0; v < 18; v++) begin
      drive(vecs[v].alu_v, vecs[v].alu_rd, vecs[v].alu_d,
            vecs[v].lsu_v, vecs[v].lsu_rd, vecs[v].lsu_d);
      tick();
      chk_out($sformatf("vec%0d", v), vecs[v].e_we, vecs[v].e_rd, vecs[v].e_data,
              vecs[v].e_ready, vecs[v].e_cnt, vecs[v].e_mask);
    end

    // Queued LSU rd=7 squashed by a later ALU write to rd=7.
    drive(1'b1, 5'd20, 32'h1, 1'b1, 5'd7, 32'hAA);
    tick();
    chk_out("waw_q", 1'b1, 5'd20, 32'h1, 1'b1, 3'd1, 32'h80);
    drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'h0);
    tick();
    chk_out("waw_alu", 1'b1, 5'd7, 32'hBB, 1'b1, 3'd1, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_out("waw_drain", 1'b0, 5'd7, 32'hBB, 1'b1, 3'd0, 32'h0);

    // Same-cycle LSU and ALU to rd=9.
`ifdef WB_WRITER_STATS_EN
    sq_before = stat_squash;
`endif
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h55);
    tick();
    chk_out("same_alu", 1'b1, 5'd9, 32'h99, 1'b1, 3'd1, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_out("same_drain", 1'b0, 5'd9, 32'h99, 1'b1, 3'd0, 32'h0);
`ifdef WB_WRITER_STATS_EN
    chk("stat_squash_delta", stat_squash - sq_before, 32'd1);
`endif

    // Reset while two rd=3 entries are draining.
    drive(1'b1, 5'd21, 32'h21, 1'b1, 5'd3, 32'h33);
    tick();
    chk_out("rst_q1", 1'b1, 5'd21, 32'h21, 1'b1, 3'd1, 32'h8);
    drive(1'b1, 5'd22, 32'h22, 1'b1, 5'd3, 32'h34);
    tick();
    chk_out("rst_q2", 1'b1, 5'd22, 32'h22, 1'b1, 3'd2, 32'h8);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_out("rst_drain", 1'b1, 5'd3, 32'h33, 1'b1, 3'd1, 32'h8);
    reset = 1'b1;
    tick();
    chk_out("rst_mid", 1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    reset = 1'b0;
    tick();
    chk_out("rst_rel", 1'b0, 5'd0, 32'h0, 1'b1, 3'd0, 32'h0);
    tick();
    chk_out("rst_idle", 1'b0, 5'd0, 32'h0, 1'b1, 3'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
Writeback-side driver for the pipelined register file's single write port.
- Merges two result sources: the single-cycle ALU path (fixed priority, no backpressure) and the load/store unit (LSU; valid/ready handshake, buffered in a small FIFO).
- Emits at most one write per cycle on wb_rd/wb_data/wb_we, which connect to the register file's rd/rd_data_in/we.
- Provides a pending-write mask so decode can stall on registers with queued loads.

Parameters:
DEPTH, 4, LSU FIFO entries; power of two, >= 2
AW, $clog2(DEPTH), FIFO pointer width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
alu_valid  in  1  ALU result present this cycle; always accepted
alu_rd  in  5  ALU destination register
alu_data  in  32  ALU result
lsu_valid  in  1  LSU result offered
lsu_ready  out  1  FIFO can accept; transfer when lsu_valid && lsu_ready
lsu_rd  in  5  LSU destination register
lsu_data  in  32  LSU load data
wb_we  out  1  register-file write enable (registered)
wb_rd  out  5  register-file write address (registered)
wb_data  out  32  register-file write data (registered)
pending_mask  out  32  bit i = 1 while a live FIFO entry targets register i
fifo_count  out  AW+1  FIFO occupancy, including squashed entries

Behaviour:
Reset (synchronous, active-high):
- FIFO emptied; all entries invalid.
- wb_we=0, wb_rd=0, wb_data=0, pending_mask=0, fifo_count=0.
- lsu_ready=0 while reset is high; 1 in the first cycle after reset falls.
- Reset mid-operation discards all queued entries without writing them.

FIFO handshake:
- lsu_ready = !full, from registered state only. No same-cycle pass-through when full.
- Accepted entry stores {live=1, rd, data}.
- If lsu_rd==0, the entry is accepted but stored with live=0.

Output select, evaluated each cycle; output registered, so latency is 1 cycle from input to wb_*:
- alu_valid && alu_rd!=0: next cycle wb_we=1, wb_rd=alu_rd, wb_data=alu_data. FIFO head is not popped.
- alu_valid && alu_rd==0: next cycle wb_we=0. FIFO head is not popped.
- Otherwise, if FIFO non-empty: pop the head. If the head is live, next cycle wb_we=1 with the head's rd/data. If the head is squashed, next cycle wb_we=0. Squashed entries consume one drain cycle.
- Otherwise wb_we=0; wb_rd and wb_data hold their last values.

WAW squash (ALU results are younger than any queued LSU result):
- When alu_valid && alu_rd!=0, every FIFO entry with rd==alu_rd is marked live=0 in the same cycle.
- An LSU entry accepted in the same cycle with lsu_rd==alu_rd is stored with live=0.

Simultaneous operation:
- Enqueue and dequeue in the same cycle leave fifo_count unchanged.
- Pointers wrap modulo DEPTH.
- Full plus pop: lsu_ready rises the next cycle.

pending_mask:
- Combinational OR over live FIFO entries of (1<<rd).
- Bit 0 is always 0.
- Reflects registered FIFO state only; it excludes the entry being written on wb_* this cycle.

Optional Feature:
Macro WB_WRITER_STATS_EN.
- Defined: adds outputs stat_alu_wr[31:0] (ALU writes issued), stat_lsu_wr[31:0] (live LSU writes issued) and stat_squash[31:0] (entries marked or stored with live=0, including rd==0 entries).
- Counters are zeroed by reset, increment by at most 1 per event per cycle, and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset high 2 cycles, then drop -> wb_we=0, fifo_count=0, pending_mask=0, lsu_ready 0 during reset and 1 after.
2. alu_valid, rd=5, data=0x1234 for one cycle -> next cycle wb_we=1, wb_rd=5, wb_data=0x1234; the cycle after, wb_we=0.
3. alu_valid every cycle for 6 cycles while pushing LSU rd=1,2,3,4 (DEPTH=4) -> lsu_ready=0 after the 4th push; pending_mask=0x1E; after ALU stops, LSU writes 1,2,3,4 appear in order on consecutive cycles and pending_mask returns to 0.
4. LSU push rd=7, data=0xAA while ALU stalls it; then ALU writes rd=7, data=0xBB -> pending_mask bit 7 clears; the FIFO drain cycle shows wb_we=0; register 7 receives only 0xBB.
5. Same-cycle LSU rd=9 and ALU rd=9 -> only the ALU write is issued; the LSU entry drains with wb_we=0; stat_squash=1 when WB_WRITER_STATS_EN is defined.
6. LSU rd=3 queued and ALU idle, then reset asserted mid-drain -> no write to register 3 after reset; fifo_count=0 next cycle.
